vram_write_arbiter: RTL
=======================

# vram_write_arbiter

Write-port controller for the 2048×8 video RAM. Shares the RAM's single write port between two requesters: game-logic updates (requester 0) and the score/text overlay (requester 1). Arbitration is round-robin. An optional built-in clear sequencer fills the whole RAM with a constant. The block sits in the write-clock domain and drives the RAM's `wea`/`addra`/`dia` inputs directly.

## Interface
- `ADDR_W`, 11, RAM address width; depth is 2^ADDR_W.
- `DATA_W`, 8, RAM data width.
- `FILL`, 8'h00, data value written by the clear sequencer.

Ports:
- `clk`  in  1  Single clock; the same clock as the RAM write clock.
- `rst_n`  in  1  Reset; asynchronous, active-low.
- `req0` / `req1`  in  1  Write request from requester 0 / 1. Held until granted.
- `addr0` / `addr1`  in  ADDR_W  Write address; stable while the matching req is high.
- `data0` / `data1`  in  DATA_W  Write data; stable while the matching req is high.
- `gnt0` / `gnt1`  out  1  Combinational grant. A transfer occurs on a rising edge where reqN and gntN are both high.
- `clear_start`  in  1  Request to fill the whole RAM with FILL.
- `clear_busy`  out  1  High while the clear sequence owns the port.
- `clear_done`  out  1  One-cycle pulse marking the final clear write.
- `wea`  out  1  RAM write enable; registered.
- `addra`  out  ADDR_W  RAM write address; registered.
- `dia`  out  DATA_W  RAM write data; registered.

## Operation
- States: IDLE and CLEAR. CLEAR exists only with the configuration macro defined.
- **IDLE grant logic:**
  - If `clear_start` is high, no grant is issued that cycle.
  - Otherwise, with a single active req, that requester is granted.
  - With both reqs active, the requester not granted last is granted.
- **Round-robin pointer:**
  - `last` is updated on each transfer.
  - Reset value is 1, so requester 0 wins the first tie.
  - A lone requester can be granted on consecutive cycles (full throughput, one write per cycle).
- **Transfer:** on the edge, `wea`<=1, `addra`<=addrN, `dia`<=dataN. With no transfer, `wea`<=0 and `addra`/`dia` hold.
- **IDLE → CLEAR:** `clear_start` sampled high in IDLE.
  - Sets the counter `cnt`<=0 and `clear_busy`<=1.
  - Has priority over same-cycle reqs; those reqs stay pending.
- **In CLEAR:**
  - `gnt0`/`gnt1` are 0.
  - Each edge issues `wea`<=1, `addra`<=cnt, `dia`<=FILL, then `cnt`++.
  - `clear_start` is ignored.
- **CLEAR → IDLE:** on the edge that issues address 2^ADDR_W−1.
  - Same edge: `clear_busy`<=0 and `clear_done`<=1 for exactly one cycle.
  - The counter never wraps.
- **Reset (any time, including mid-clear):**
  - Registered outputs: `wea`, `addra`, `dia`, `clear_busy`, `clear_done` all 0.
  - Internal state: IDLE, `cnt` 0, `last` 1.
  - `gnt0`/`gnt1` are forced 0 while `rst_n` is low.
  - A partially completed clear is abandoned and not resumed.

## Timing
- **Request latency:** req high in cycle N with grant → `wea` high in cycle N+1 carrying that address/data. Best case is 1 cycle.
- **Worst case with both requesters saturating:** a request waits one extra cycle. Outside a clear, a pending request is granted within 2 cycles.
- **Clear timing:**
  - `clear_start` sampled at edge E0 → `clear_busy` high from E0.
  - First clear write (address 0) is visible after E1.
  - Write to address k is visible after E(k+1).
  - The final write (address 2047) and `clear_done` are both visible after E2048.
  - Total: 2048 write cycles, no gaps.
- **Returning to IDLE:** grants are legal in the cycle `clear_done` is high, so a requester write can appear in the very next cycle (back-to-back with the clear).
- **Requester deadline during a clear:** a request asserted during CLEAR is served within 2 cycles after `clear_done`.

## Configuration
- `VRAM_CLEAR_EN` defined:
  - CLEAR state, counter, FILL writes, `clear_busy` and `clear_done` behave as above.
- `VRAM_CLEAR_EN` undefined:
  - No CLEAR state and no counter.
  - `clear_start` is ignored and does not block grants.
  - `clear_busy` and `clear_done` are tied 0.
  - Arbitration is unchanged.

## Test plan
- **Reset values:** check during `rst_n`=0 and after release → `wea`/`addra`/`dia`/`clear_busy`/`clear_done`/`gnt0`/`gnt1` all 0.
- **Single requester:** req0 held 3 cycles with addr0 = 0x010, 0x011, 0x012 (data 0xA1–0xA3) → `gnt0` high all 3 cycles; `wea` high 3 consecutive cycles one cycle later, with matching addra/dia.
- **Contention:** req0 and req1 high together for 4 cycles (addr0=0x100, addr1=0x200) → grants alternate 0,1,0,1; `addra` sequence 0x100, 0x200, 0x100, 0x200.
- **Clear with FILL=8'h5A:** pulse `clear_start`, with req1 raised mid-clear → exactly 2048 writes to addresses 0..2047 with `dia`=0x5A. Also check:
  - `gnt1`=0 throughout the clear.
  - One-cycle `clear_done` coincides with the address-2047 write.
  - req1's write appears the next cycle.
- **Simultaneous start:** `clear_start` and req0 in the same cycle → no `gnt0` that cycle; the clear runs first; req0 is served right after `clear_done`.
- **Reset mid-clear:** drop `rst_n` at address 1000, release it, then issue req0 (addr 0x7FF, data 0x33) → outputs 0 during reset; after release, state is IDLE with no further clear writes; req0's write is issued.

Source files
------------

// File: rtl/vram_write_arbiter.sv
// Round-robin write-port arbiter for the 2048x8 video RAM: two requesters share wea/addra/dia.
// Optional clear sequencer (fills every address with FILL) is built only when VRAM_CLEAR_EN is defined.
module vram_write_arbiter #(
  parameter int                ADDR_W = 11,
  parameter int                DATA_W = 8,
  parameter logic [DATA_W-1:0] FILL   = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] data0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] data1,
  output logic              gnt0,
  output logic              gnt1,
  input  logic              clear_start,
  output logic              clear_busy,
  output logic              clear_done,
  output logic              wea,
  output logic [ADDR_W-1:0] addra,
  output logic [DATA_W-1:0] dia
);

  logic              r_wea;
  logic [ADDR_W-1:0] r_addra;
  logic [DATA_W-1:0] r_dia;
  logic              r_last;   // requester that won the most recent transfer
  logic              w_open;   // port available to requesters this cycle
  logic              w_gnt0;
  logic              w_gnt1;

`ifdef VRAM_CLEAR_EN
  typedef enum logic {S_IDLE, S_CLEAR} state_t;
  state_t            r_state;
  logic [ADDR_W-1:0] r_cnt;
  logic              r_busy;
  logic              r_done;

  // A clear request in IDLE takes the port this cycle; the reqs simply stay pending.
  assign w_open     = (r_state == S_IDLE) && !clear_start;
  assign clear_busy = r_busy;
  assign clear_done = r_done;
`else
  logic w_unused;

  assign w_open     = 1'b1;
  assign clear_busy = 1'b0;
  assign clear_done = 1'b0;
  assign w_unused   = clear_start | (|FILL);
`endif

  assign w_gnt0 = rst_n && w_open && req0 && (!req1 || r_last);
  assign w_gnt1 = rst_n && w_open && req1 && (!req0 || !r_last);
  assign gnt0   = w_gnt0;
  assign gnt1   = w_gnt1;
  assign wea    = r_wea;
  assign addra  = r_addra;
  assign dia    = r_dia;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wea   <= 1'b0;
      r_addra <= '0;
      r_dia   <= '0;
      r_last  <= 1'b1;
`ifdef VRAM_CLEAR_EN
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
`endif
    end else begin
      r_wea <= w_gnt0 | w_gnt1;
      if (w_gnt0 | w_gnt1) begin
        r_addra <= w_gnt1 ? addr1 : addr0;
        r_dia   <= w_gnt1 ? data1 : data0;
        r_last  <= w_gnt1;
      end
`ifdef VRAM_CLEAR_EN
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (clear_start) begin
            r_state <= S_CLEAR;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
          end
        end
        S_CLEAR: begin
          r_wea   <= 1'b1;
          r_addra <= r_cnt;
          r_dia   <= FILL;
          if (&r_cnt) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
`endif
    end
  end

endmodule
